// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin over WIDTH bits, BITS_PER_CYCLE bits per clock, LSB slice first.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(N - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({BITS_PER_CYCLE{1'b1}});

  generate
    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               br_q, br_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  // Slice datapath: the current slice of the captured operands, rippled through a
  // chain of full subtractors seeded by the registered borrow.
  int                        shamt;
  logic [BITS_PER_CYCLE-1:0] a_sl, b_sl, d_sl;
  logic                      ripple;
  logic [WIDTH-1:0]          diff_upd;

  always_comb begin
    shamt  = int'(cnt_q) * BITS_PER_CYCLE;
    a_sl   = BITS_PER_CYCLE'(a_q >> shamt);
    b_sl   = BITS_PER_CYCLE'(b_q >> shamt);
    d_sl   = '0;
    // NOTE: blocking assignments are intentional here; ripple must carry from bit i to bit i+1
    // within the same evaluation, which non-blocking updates would not do.
    ripple = br_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      d_sl[i] = a_sl[i] ^ b_sl[i] ^ ripple;
      ripple  = (~a_sl[i] & b_sl[i]) | (~(a_sl[i] ^ b_sl[i]) & ripple);
    end
    diff_upd = (diff_q & ~(SLICE_MASK << shamt)) | (WIDTH'(d_sl) << shamt);
  end

  always_comb begin
    // NOTE: every _d starts from its held value so no path through the case leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          diff_d  = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        diff_d = diff_upd;
        br_d   = ripple;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          bout_d  = ripple;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_upd[WIDTH-1] != a_q[WIDTH-1]);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: operand registers are reset along with control so an aborted operation leaves
  // no stale data; they are plain flops, not a memory, so this costs nothing extra.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised, multi-cycle subtractor that computes A - B - Bin over WIDTH bits, BITS_PER_CYCLE bits per clock, LSB slice first.
- A registered borrow carries between slices; each slice is the full-subtractor equation applied bit by bit.
- Start/busy/done handshake; used where a wide combinational subtractor costs too much area or timing.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- BITS_PER_CYCLE, 1, bits processed per clock. Must divide WIDTH exactly; otherwise elaboration fails.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while busy=0.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  difference, held until the next accepted start.
- bout  output  1  final borrow-out, held with diff.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; busy=0, done=0, diff=0, bout=0; slice counter=0; borrow register=0; operand registers=0.
- States: IDLE, RUN.
- IDLE: start=1 at edge E0 -> capture a, b, bin; borrow register=bin; counter=0; diff cleared to 0; go to RUN; busy=1 from the cycle after E0.
- RUN: each edge processes slice k = counter, bits [k*BPC +: BPC].
  - Per bit: d = a^b^br; br' = (~a&b) | (~(a^b)&br), rippling inside the slice.
  - Slice bits are written into diff; borrow register takes the slice's borrow-out; counter increments.
- Last slice, N = WIDTH/BITS_PER_CYCLE, processed at edge E_N: bout = final borrow; done=1 and busy=0 in the cycle after E_N; state -> IDLE.
- Latency: done is high exactly N cycles after the accepting edge. WIDTH=8, BPC=1 gives 8 cycles; BPC=8 gives 1 cycle.
- done lasts exactly one cycle. A new start may be accepted in the same cycle done=1, because busy=0 then.
- start while busy=1: ignored. Operands and progress are unaffected; no queuing.
- diff and bout are stable, showing the last completed result, except during RUN, where diff bits update slice by slice. Consumers use diff only on done or while busy=0.
- Arithmetic:
  - diff = (a - b - bin) mod 2^WIDTH.
  - bout = 1 iff unsigned a < b + bin.
  - Wrap-around is normal: 0 - 1 gives all ones with bout=1.
- Reset asserted mid-operation: immediate abort to reset values; no done pulse; the operation is lost.
- Operand inputs changing after the accepting edge have no effect on the result.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), reset 0, updated on edge E_N together with bout.
  - ovf = two's-complement signed overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using captured operands and final diff.
  - ovf is held like bout.
- Not defined: no ovf port or logic; all other behaviour identical.

Test Plan:
- WIDTH=8, BPC=1: reset, then start with a=0x05, b=0x03, bin=0 -> busy=1 for 8 cycles; done pulses 8 cycles after the accepting edge; diff=0x02, bout=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0. Issue the second start in the done cycle -> accepted, no idle gap.
- Start a=0x80, b=0x01 with OVF_EN defined -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0x01 -> diff=0x7E, ovf=0.
- During RUN, pulse start with a=0xFF, b=0x00 and change the a/b inputs each cycle -> ignored; the original result (e.g. 0x02) is delivered on schedule.
- Assert rst_n=0 at cycle 4 of RUN -> busy, done, diff and bout go to 0 asynchronously; no done pulse after release; the next start runs normally.
- WIDTH=16, BPC=4: a=0x1234, b=0x2345, bin=0 -> done after 4 cycles; diff=0xEEEF, bout=1.
